// File: rtl/ir_seq_pkg.sv
// Shared types and constants for the IR line-sensor sweep sequencer.
// Channel weights are powers of two, so each term is a shift plus an optional negate.
package ir_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int RES_W  = 12;
    localparam int ERR_W  = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_t;

    // Shift amount per channel, ch7 in the top bits: |weight| = 8,4,2,1,1,2,4,8 for ch0..ch7.
    localparam logic [2*NUM_CH-1:0] CH_SHIFT = {2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    function automatic logic signed [ERR_W-1:0] ch_term(input logic [CH_W-1:0] ch,
                                                         input logic [RES_W-1:0] val);
        logic [ERR_W-1:0] mag;
        mag = {{(ERR_W-RES_W){1'b0}}, val} << CH_SHIFT[2*ch +: 2];
        // Lower half of the array (ch0..ch3) carries negative weight.
        return ch[CH_W-1] ? $signed(mag) : -$signed(mag);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the settle delay and the conversion timeout.
// Load takes effect next cycle; counter holds at zero, where expired_o is high.
module seq_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o     = cnt_q;
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ir_sweep_seq.sv
// Runs one 8-channel IR sweep per strt_sweep: settle, convert each channel, accumulate weighted error.
// strt_sweep is dropped while busy; each conversion waits on cnv_cmplt up to TMO_CYC cycles before faulting.
module ir_sweep_seq
    import ir_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 4096,
    parameter int TMO_CYC    = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    strt_sweep,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        res,
    output logic                    strt_cnv,
    output logic [CH_W-1:0]         chnnl,
    output logic                    IR_en,
    output logic                    busy,
    output logic signed [ERR_W-1:0] error,
    output logic                    err_vld,
    output logic                    fault
);

    localparam int TMR_MAX = (SETTLE_CYC > TMO_CYC) ? SETTLE_CYC : TMO_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(TMO_CYC - 1);

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           idx_q, idx_d;
    logic signed [ERR_W-1:0]   acc_q, acc_d;
    logic signed [ERR_W-1:0]   error_q;
    logic                      fault_q, fault_d;
    logic                      strt_cnv_q, ir_en_q, busy_q, err_vld_q;
    logic                      run_d;
    logic                      tmr_load;
    logic [TMR_W-1:0]          tmr_val;
    logic [TMR_W-1:0]          tmr_cnt;
    logic                      tmr_expired;
    logic                      wait_first;

    seq_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .cnt_o      (tmr_cnt),
        .expired_o  (tmr_expired)
    );

    // The timer still holds its load value on the first WAIT cycle, when the A2D flag may be stale.
    assign wait_first = (tmr_cnt == TMO_LD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        fault_d  = fault_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (strt_sweep) begin
                    state_d  = S_SETTLE;
                    idx_d    = '0;
                    acc_d    = '0;
                    fault_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            S_SETTLE: begin
                if (tmr_expired) state_d = S_START;
            end
            S_START: begin
                state_d  = S_WAIT;
                tmr_load = 1'b1;
                tmr_val  = TMO_LD;
            end
            S_WAIT: begin
                if (cnv_cmplt && !wait_first) begin
                    state_d = S_ACCUM;
                end else if (tmr_expired) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + ch_term(idx_q, res);
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_START;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        run_d = (state_d == S_SETTLE) || (state_d == S_START) ||
                (state_d == S_WAIT)   || (state_d == S_ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            acc_q      <= '0;
            error_q    <= '0;
            fault_q    <= 1'b0;
            strt_cnv_q <= 1'b0;
            ir_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_vld_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            fault_q    <= fault_d;
            strt_cnv_q <= (state_d == S_START);
            ir_en_q    <= run_d;
            busy_q     <= run_d;
            err_vld_q  <= (state_q == S_DONE);
            if (state_q == S_DONE) error_q <= acc_q;
        end
    end

    assign strt_cnv = strt_cnv_q;
    assign chnnl    = idx_q;
    assign IR_en    = ir_en_q;
    assign busy     = busy_q;
    assign error    = error_q;
    assign err_vld  = err_vld_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_ir_sweep_seq.sv
// Bench for ir_sweep_seq: A2D model with stale-flag behaviour and per-channel latency,
// scoreboard of expected line errors popped on err_vld.
module tb_ir_sweep_seq;

    localparam int SETTLE_CYC = 4096;
    localparam int TMO_CYC    = 1023;
    // A2D model answers channel c after 4+c WAIT cycles, so a sweep spans 8*2 + (4+...+11) = 76 cycles of conversion.
    localparam int SWEEP_LAT  = 1 + SETTLE_CYC + 76 + 1;
    localparam int BUDGET     = SETTLE_CYC + TMO_CYC + 200;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               strt_sweep = 1'b0;
    logic               cnv_cmplt = 1'b1;
    logic [11:0]        res = 12'd0;
    logic               strt_cnv;
    logic [2:0]         chnnl;
    logic               IR_en;
    logic               busy;
    logic signed [16:0] error;
    logic               err_vld;
    logic               fault;

    always #5 clk = ~clk;

    ir_sweep_seq #(
        .SETTLE_CYC (SETTLE_CYC),
        .TMO_CYC    (TMO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .strt_sweep (strt_sweep),
        .cnv_cmplt  (cnv_cmplt),
        .res        (res),
        .strt_cnv   (strt_cnv),
        .chnnl      (chnnl),
        .IR_en      (IR_en),
        .busy       (busy),
        .error      (error),
        .err_vld    (err_vld),
        .fault      (fault)
    );

    int     n_checks = 0;
    int     n_fails  = 0;
    int     cyc      = 0;
    int     ch_val[8];
    int     wgt[8]   = '{-8, -4, -2, -1, 1, 2, 4, 8};
    int     drop_ch  = -1;
    int     m_cnt    = 0;
    bit     m_act    = 1'b0;
    int     m_ch     = 0;
    int     exp_ch   = 0;
    int     ir_cnt   = 0;
    int     n_cnv    = 0;
    longint last_err = 0;
    longint sb[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_err();
        longint s = 0;
        for (int i = 0; i < 8; i++) s += longint'(wgt[i]) * longint'(ch_val[i]);
        return s;
    endfunction

    task automatic fill(input int lo_v, input int hi_v);
        for (int i = 0; i < 8; i++) ch_val[i] = (i < 4) ? lo_v : hi_v;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // A2D model: flag stays stale through the first WAIT cycle with a garbage result on res.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_act  = 1'b0;
            exp_ch = 0;
            ir_cnt = 0;
        end else begin
            ir_cnt = IR_en ? ir_cnt + 1 : 0;
            if (!busy) exp_ch = 0;
            if (strt_cnv) begin
                if (exp_ch == 0) chk("settle_ir_en", ir_cnt, SETTLE_CYC + 1);
                chk("chnnl_order", chnnl, exp_ch);
                m_ch  = int'(chnnl);
                exp_ch++;
                n_cnv++;
                m_cnt = 0;
                m_act = 1'b1;
                res   = 12'hFFF;
            end else if (m_act) begin
                m_cnt++;
                if (m_cnt == 2) cnv_cmplt = 1'b0;
                if (m_cnt == 4 + m_ch) begin
                    if (m_ch != drop_ch) begin
                        res       = 12'(ch_val[m_ch]);
                        cnv_cmplt = 1'b1;
                    end
                    m_act = 1'b0;
                end
            end
            if (err_vld) begin
                if (sb.size() == 0) chk("err_vld_unexpected", 1, 0);
                else chk("error", $signed(error), sb.pop_front());
            end
        end
    end

    task automatic run_sweep(input int poke, input int drop, input int exp_lat, input int exp_ncnv);
        int     c0;
        int     k;
        int     n0;
        bit     seen;
        longint e;
        drop_ch = drop;
        e = model_err();
        if (drop < 0) sb.push_back(e);
        n0 = n_cnv;
        @(posedge clk); #2;
        strt_sweep = 1'b1;
        c0   = cyc;
        seen = 1'b0;
        k    = 0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(posedge clk); #2;
            k = cyc - c0;
            strt_sweep = (k == poke);
            if (err_vld || fault) seen = 1'b1;
        end
        strt_sweep = 1'b0;
        if (!seen) chk("sweep_end_timeout", 0, 1);
        chk("latency", k, exp_lat);
        chk("fault", fault, (drop >= 0) ? 1 : 0);
        chk("n_strt_cnv", n_cnv - n0, exp_ncnv);
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ir_en", IR_en, 0);
        if (drop >= 0) chk("error_hold", $signed(error), last_err);
        else last_err = e;
    endtask

    task automatic reset_in_ch5();
        bit seen = 1'b0;
        drop_ch = -1;
        @(posedge clk); #2;
        strt_sweep = 1'b1;
        @(posedge clk); #2;
        strt_sweep = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(posedge clk); #2;
            if (strt_cnv && chnnl == 3'd5) seen = 1'b1;
        end
        if (!seen) chk("reach_ch5_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strt_cnv", strt_cnv, 0);
        chk("mid_rst_ir_en", IR_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err_vld", err_vld, 0);
        chk("mid_rst_fault", fault, 0);
        chk("mid_rst_chnnl", chnnl, 0);
        chk("mid_rst_error", $signed(error), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        last_err = 0;
    endtask

    initial begin
        #1;
        chk("rst_strt_cnv", strt_cnv, 0);
        chk("rst_ir_en", IR_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_vld", err_vld, 0);
        chk("rst_fault", fault, 0);
        chk("rst_chnnl", chnnl, 0);
        chk("rst_error", $signed(error), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_strt_cnv", strt_cnv, 0);

        fill(100, 100);
        run_sweep(10, -1, SWEEP_LAT, 8);
        fill(0, 0);
        ch_val[7] = 4095;
        run_sweep(-1, -1, SWEEP_LAT, 8);
        fill(0, 0);
        ch_val[0] = 4095;
        run_sweep(-1, -1, SWEEP_LAT, 8);
        fill(4095, 0);
        run_sweep(-1, -1, SWEEP_LAT, 8);
        fill(0, 4095);
        run_sweep(SWEEP_LAT - 1, -1, SWEEP_LAT, 8);
        fill(100, 100);
        run_sweep(-1, 3, 1 + SETTLE_CYC + 22 + TMO_CYC, 4);

        for (int i = 0; i < 8; i++) ch_val[i] = 300 * i + 7;
        reset_in_ch5();
        run_sweep(-1, -1, SWEEP_LAT, 8);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ir_sweep_seq.md
IR_SWEEP_SEQ -- requirements
Module: ir_sweep_seq

Interface
REQ-001 Parameter: SETTLE_CYC, 4096, clk cycles between IR_en rising and the first conversion request.
REQ-002 Parameter: TMO_CYC, 1023, maximum clk cycles to wait for cnv_cmplt per conversion.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 strt_sweep  input  1  one-cycle request to run one 8-channel sweep.
REQ-006 cnv_cmplt  input  1  from A2D interface; level, cleared by strt_cnv, set when res is valid.
REQ-007 res  input  12  unsigned conversion result from A2D interface.
REQ-008 strt_cnv  output  1  one-cycle conversion request to A2D interface.
REQ-009 chnnl  output  3  channel to convert; stable from strt_cnv until the result is accumulated.
REQ-010 IR_en  output  1  IR emitter enable.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 error  output  17  signed weighted line error of the last completed sweep.
REQ-013 err_vld  output  1  one-cycle pulse when error updates.
REQ-014 fault  output  1  sticky conversion-timeout flag.

Function
REQ-015 States: IDLE, SETTLE, START, WAIT, ACCUM, DONE.
REQ-016 IDLE: strt_sweep -> SETTLE; busy, IR_en set; accumulator cleared; channel index 0; fault cleared.
REQ-017 strt_sweep while busy is ignored.
REQ-018 SETTLE: hold SETTLE_CYC cycles, then -> START.
REQ-019 START: strt_cnv high exactly one cycle with chnnl = index; -> WAIT.
REQ-020 WAIT: cnv_cmplt ignored on the first WAIT cycle (A2D clears its stale flag then); from the second cycle, cnv_cmplt high -> ACCUM.
REQ-021 WAIT: TMO_CYC cycles without cnv_cmplt -> IDLE with fault set, IR_en low, busy low, error and err_vld unchanged.
REQ-022 ACCUM (one cycle): acc += weight(index) * res; weights ch0..ch7 = -8,-4,-2,-1,+1,+2,+4,+8 implemented as shifts; index 7 -> DONE else index+1 and -> START.
REQ-023 Accumulator and error 17-bit signed; range +/-61425, no overflow or saturation.
REQ-024 DONE (one cycle): error <= acc; err_vld pulse; IR_en, busy low; -> IDLE.
REQ-025 IR_en stays high continuously SETTLE through ACCUM; no re-settle between channels.
REQ-026 strt_sweep in the DONE cycle is ignored; a sweep may start the following cycle.
REQ-027 Latency: strt_sweep to err_vld = 1 + SETTLE_CYC + sum over 8 channels of (START + WAIT cycles + ACCUM) + 1.

Reset
REQ-028 rst_n low, at any time including mid-sweep: state IDLE; strt_cnv, IR_en, busy, err_vld, fault 0; chnnl 0; error 0; accumulator and counters 0.
REQ-029 No conversion request is issued in the first cycle after reset deassertion.

Structure
REQ-030 Package ir_seq_pkg holds the state enum, weight/shift table, channel count 8 and result width 12.
REQ-031 One sub-module, seq_timer: loadable down-counter shared by SETTLE and WAIT timeout, signals expiry.
REQ-032 Output strt_cnv, IR_en, err_vld and busy are registered.

Verification
REQ-033 A2D model returns res=100 on all channels; strt_sweep -> 8 strt_cnv pulses, chnnl 0..7 in order, err_vld once, error = 0.
REQ-034 ch7=4095, others 0 -> error = +32760; ch0=4095, others 0 -> error = -32760.
REQ-035 ch0..3=4095, ch4..7=0 -> error = -61425; reversed -> +61425, no wrap.
REQ-036 A2D model never asserts cnv_cmplt on ch3 -> fault high after TMO_CYC cycles, IR_en/busy low, error holds previous value, no err_vld.
REQ-037 rst_n pulsed low during WAIT of ch5 -> all outputs at reset values; next sweep starts at ch0 with full SETTLE_CYC delay.
REQ-038 Stale cnv_cmplt held high from previous sweep -> no accumulation in the first WAIT cycle; IR_en high for at least SETTLE_CYC cycles before the first strt_cnv.
